// File: rtl/register_bank_fwd.sv
// ID-stage register bank: one write port, two forwarded read ports, immediate on B,
// load-use hazard detection and the ID/EX operand register. Build option: REGBANK_R0_ZERO_EN.
module register_bank_fwd #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_id,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic [DATA_W-1:0] imm,
    input  logic              imm_sel,
    input  logic [ADDR_W-1:0] rd_ex,
    input  logic              wen_ex,
    input  logic              load_ex,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [ADDR_W-1:0] rd_dm,
    input  logic              wen_dm,
    input  logic [DATA_W-1:0] ans_dm,
    input  logic [ADDR_W-1:0] RW_wb,
    input  logic              we_wb,
    input  logic [DATA_W-1:0] ans_wb,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              valid_out,
    output logic              hazard,
    output logic [1:0]        fwd_A,
    output logic [1:0]        fwd_B
);

`ifdef REGBANK_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    localparam logic [1:0] SRC_FILE = 2'b00;
    localparam logic [1:0] SRC_WB   = 2'b01;
    localparam logic [1:0] SRC_DM   = 2'b10;
    localparam logic [1:0] SRC_EX   = 2'b11;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] read_a, read_b;

    // With the R0 option, address 0 never matches any producer.
    function automatic logic addr_hit(input logic [ADDR_W-1:0] dst, input logic [ADDR_W-1:0] src);
        return (dst == src) && !(R0_ZERO && (src == '0));
    endfunction

    function automatic logic [DATA_W-1:0] file_rd(input logic [ADDR_W-1:0] x);
        if (32'(x) >= NUM_REGS || (R0_ZERO && (x == '0)))
            return '0;
        return regs_q[x];
    endfunction

    function automatic logic [1:0] pick_src(input logic [ADDR_W-1:0] x);
        if (wen_ex && addr_hit(rd_ex, x))      return SRC_EX;
        else if (wen_dm && addr_hit(rd_dm, x)) return SRC_DM;
        else if (we_wb && addr_hit(RW_wb, x))  return SRC_WB;
        return SRC_FILE;
    endfunction

    function automatic logic [DATA_W-1:0] src_val(input logic [1:0] sel, input logic [ADDR_W-1:0] x);
        case (sel)
            SRC_EX:  return ans_ex;
            SRC_DM:  return ans_dm;
            SRC_WB:  return ans_wb;
            default: return file_rd(x);
        endcase
    endfunction

    always_comb begin
        regs_d = regs_q;
        if (we_wb && 32'(RW_wb) < NUM_REGS && !(R0_ZERO && (RW_wb == '0)))
            regs_d[RW_wb] = ans_wb;
    end

    always_comb begin
        fwd_A  = pick_src(RA);
        fwd_B  = pick_src(RB);
        read_a = src_val(fwd_A, RA);
        read_b = src_val(fwd_B, RB);
        hazard = valid_id && wen_ex && load_ex &&
                 (addr_hit(rd_ex, RA) || (!imm_sel && addr_hit(rd_ex, RB)));
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        a_d     = a_q;
        b_d     = b_q;
        valid_d = valid_q;
        if (flush || (!stall && hazard)) begin
            a_d     = '0;
            b_d     = '0;
            valid_d = 1'b0;
        end else if (!stall) begin
            a_d     = read_a;
            b_d     = imm_sel ? imm : read_b;
            valid_d = valid_id;
        end
    end

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file itself is architecturally reset, so the memory is cleared too.
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_register_bank_fwd.sv
// Directed self-checking bench for register_bank_fwd (NUM_REGS=24 to exercise the address boundary).
module tb_register_bank_fwd;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 24;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              stall, flush, valid_id, imm_sel;
    logic [ADDR_W-1:0] RA, RB, rd_ex, rd_dm, RW_wb;
    logic              wen_ex, load_ex, wen_dm, we_wb;
    logic [DATA_W-1:0] imm, ans_ex, ans_dm, ans_wb;
    logic [DATA_W-1:0] A, B;
    logic              valid_out, hazard;
    logic [1:0]        fwd_A, fwd_B;

    int checks = 0;
    int errors = 0;

    register_bank_fwd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_id(valid_id),
        .RA(RA), .RB(RB), .imm(imm), .imm_sel(imm_sel),
        .rd_ex(rd_ex), .wen_ex(wen_ex), .load_ex(load_ex), .ans_ex(ans_ex),
        .rd_dm(rd_dm), .wen_dm(wen_dm), .ans_dm(ans_dm),
        .RW_wb(RW_wb), .we_wb(we_wb), .ans_wb(ans_wb),
        .A(A), .B(B), .valid_out(valid_out), .hazard(hazard), .fwd_A(fwd_A), .fwd_B(fwd_B)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; valid_id = 0; imm_sel = 0; imm = '0;
        RA = '0; RB = '0; rd_ex = '0; rd_dm = '0; RW_wb = '0;
        wen_ex = 0; load_ex = 0; wen_dm = 0; we_wb = 0;
        ans_ex = '0; ans_dm = '0; ans_wb = '0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #12;
        check("reset_A", A, 0);
        check("reset_B", B, 0);
        check("reset_valid", valid_out, 0);
        rst_n = 1'b1;
        tick();

        // Write reg 7, read it back from the file next cycle.
        we_wb = 1; RW_wb = 7; ans_wb = 16'hD000;
        tick();
        we_wb = 0; RA = 7; valid_id = 1;
        #1 check("file_fwdA", fwd_A, 2'b00);
        tick();
        check("file_A", A, 16'hD000);
        check("file_valid", valid_out, 1);

        // Same-cycle write-through.
        we_wb = 1; RW_wb = 9; ans_wb = 16'h1111; RA = 9;
        #1 check("wb_fwdA", fwd_A, 2'b01);
        tick();
        check("wb_A", A, 16'h1111);
        we_wb = 0;

        // EX beats DM, then DM alone.
        RA = 5; wen_ex = 1; rd_ex = 5; ans_ex = 16'hC000; wen_dm = 1; rd_dm = 5; ans_dm = 16'hE000;
        #1 check("ex_fwdA", fwd_A, 2'b11);
        tick();
        check("ex_A", A, 16'hC000);
        wen_ex = 0;
        #1 check("dm_fwdA", fwd_A, 2'b10);
        tick();
        check("dm_A", A, 16'hE000);
        wen_dm = 0;

        // Immediate on B still reports the forwarding source.
        RB = 6; imm_sel = 1; imm = 16'hFFFF; wen_ex = 1; rd_ex = 6; ans_ex = 16'h5A5A;
        #1 check("imm_fwdB", fwd_B, 2'b11);
        tick();
        check("imm_B", B, 16'hFFFF);
        imm_sel = 0;
        tick();
        check("reg_B", B, 16'h5A5A);

        // Load-use hazard on A inserts a bubble.
        RB = 0; RA = 3; rd_ex = 3; load_ex = 1; ans_ex = 16'h3333;
        #1 check("hazA_flag", hazard, 1);
        tick();
        check("hazA_A", A, 0);
        check("hazA_valid", valid_out, 0);
        load_ex = 0;
        #1 check("hazA_clear", hazard, 0);
        tick();
        check("post_haz_A", A, 16'h3333);
        check("post_haz_valid", valid_out, 1);

        // Hazard on B only counts when B reads the register.
        RA = 4; RB = 3; load_ex = 1; imm_sel = 1;
        #1 check("hazB_imm", hazard, 0);
        imm_sel = 0;
        #1 check("hazB_reg", hazard, 1);
        valid_id = 0;
        #1 check("haz_invalid", hazard, 0);
        valid_id = 1; load_ex = 0; RB = 0;

        // Stall holds A across changing RA, while writes still commit.
        RA = 2; rd_ex = 2; ans_ex = 16'h1234;
        tick();
        check("pre_stall_A", A, 16'h1234);
        wen_ex = 0; stall = 1; we_wb = 1; RW_wb = 12; ans_wb = 16'h0C0C;
        for (int i = 0; i < 3; i++) begin
            RA = 5'(10 + i);
            tick();
            check("stall_A", A, 16'h1234);
        end
        we_wb = 0; flush = 1;
        tick();
        check("flush_stall_A", A, 0);
        check("flush_stall_valid", valid_out, 0);
        flush = 0; stall = 0; RA = 12;
        tick();
        check("write_in_stall", A, 16'h0C0C);
        check("after_flush_valid", valid_out, 1);

        // Address boundary: last register writes, out-of-range is dropped and reads 0.
        we_wb = 1; RW_wb = 5'(NUM_REGS - 1); ans_wb = 16'hBEEF;
        tick();
        RW_wb = 5'(NUM_REGS + 1); ans_wb = 16'hDEAD;
        tick();
        we_wb = 0; RA = 5'(NUM_REGS - 1); RB = 5'(NUM_REGS + 1);
        #1 check("oor_fwdB", fwd_B, 2'b00);
        tick();
        check("last_reg_A", A, 16'hBEEF);
        check("oor_B", B, 0);

        // Register 0 behaviour depends on the build option.
        RB = 0; we_wb = 1; RW_wb = 0; ans_wb = 16'hAAAA; RA = 0;
`ifdef REGBANK_R0_ZERO_EN
        #1 check("r0_fwdA", fwd_A, 2'b00);
`else
        #1 check("r0_fwdA", fwd_A, 2'b01);
`endif
        tick();
        we_wb = 0;
        tick();
`ifdef REGBANK_R0_ZERO_EN
        check("r0_A", A, 0);
`else
        check("r0_A", A, 16'hAAAA);
`endif

        // Asynchronous reset mid-operation clears outputs and the file.
        RA = 7;
        #2 rst_n = 1'b0;
        #1 check("midrst_A", A, 0);
        check("midrst_valid", valid_out, 0);
        #3 rst_n = 1'b1;
        tick();
        check("post_rst_file", A, 0);
        check("post_rst_valid", valid_out, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
